// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM controller.
package sp_ram_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/ram_clear_seq.sv
// Sweep address counter for the RAM clear; done flags the last word.
module ram_clear_seq #(
  parameter int DEPTH = 16,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [N-1:0] cnt,
  output logic         done
);
  assign done = (cnt == N'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= done ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sp_ram_ctrl.sv
// Valid/ready front end for a single-port RAM with registered read data.
// Optional full-array clear sweep when SP_RAM_CTRL_CLEAR_EN is defined.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [N-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  ram_we,
  output logic [N-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  state_t       state;
  logic         busy, clr_go, accept, in_range;
  logic         rd_pend, rd_oor;
  logic [N-1:0] clr_cnt;

  assign in_range = ({1'b0, req_addr} < (N+1)'(DEPTH));

`ifdef SP_RAM_CTRL_CLEAR_EN
  logic clr_done;

  assign busy   = (state == CLEAR);
  assign clr_go = clr_start & ~rd_pend & ~busy;

  ram_clear_seq #(.DEPTH(DEPTH), .N(N)) u_clr (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .cnt  (clr_cnt),
    .done (clr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (clr_go)   state <= CLEAR;
        CLEAR:   if (clr_done) state <= IDLE;
        default:               state <= IDLE;
      endcase
    end
  end
`else
  logic clr_unused;

  assign clr_unused = clr_start;
  assign state      = IDLE;
  assign busy       = 1'b0;
  assign clr_go     = 1'b0;
  assign clr_cnt    = '0;
`endif

  assign clr_busy = busy;

  // Writes never wait on the read path; reads need a free response slot.
  always_comb begin
    req_ready = 1'b0;
    if (rst && state == IDLE && !clr_go)
      req_ready = req_we ? 1'b1 : (!rd_pend && (!rsp_valid || rsp_ready));
  end

  assign accept = req_valid & req_ready;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (busy && rst) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
    end else if (accept) begin
      ram_we   = req_we & in_range;
      ram_addr = req_addr;
      ram_din  = req_wdata;
    end
  end

  // RAM output is valid the cycle after the read is issued; capture it then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend   <= 1'b0;
      rd_oor    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rd_pend <= accept & ~req_we;
      if (accept && !req_we) rd_oor <= ~in_range;
      if (rd_pend) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rd_oor ? '0 : ram_dout;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
